// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: N-to-1 round-robin read/write memory arbiter with in-order read ID routing (MEM_ARB_RESP_CHECK_EN adds resp_err)
module mem_arbiter_rr #(
  parameter int REQUESTERS      = 3,
  parameter int DATA_WIDTH      = 16,
  parameter int ADDR_WIDTH      = 16,
  parameter int MAX_OUTSTANDING = 4
) (
`ifdef MEM_ARB_RESP_CHECK_EN
  output logic                             resp_err,
`endif
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [REQUESTERS*ADDR_WIDTH-1:0] rq_r_addr,
  input  logic [REQUESTERS-1:0]            rq_r_avalid,
  output logic [REQUESTERS-1:0]            rq_r_aready,
  output logic [REQUESTERS-1:0]            rq_r_dvalid,
  output logic [DATA_WIDTH-1:0]            rq_r_data,
  input  logic [REQUESTERS*ADDR_WIDTH-1:0] rq_w_addr,
  input  logic [REQUESTERS*DATA_WIDTH-1:0] rq_w_data,
  input  logic [REQUESTERS-1:0]            rq_w_valid,
  output logic [REQUESTERS-1:0]            rq_w_ready,
  output logic [ADDR_WIDTH-1:0]            m_r_addr,
  output logic                             m_r_avalid,
  input  logic                             m_r_aready,
  input  logic                             m_r_dvalid,
  input  logic [DATA_WIDTH-1:0]            m_r_data,
  output logic [ADDR_WIDTH-1:0]            m_w_addr,
  output logic [DATA_WIDTH-1:0]            m_w_data,
  output logic                             m_w_valid,
  input  logic                             m_w_ready
);
  localparam int IW = $clog2(REQUESTERS);
  localparam int FW = $clog2(MAX_OUTSTANDING);
  localparam int CW = FW + 1;
  typedef logic [IW-1:0] id_t;

  // {found, index} of the first valid requester at or after p, wrapping at REQUESTERS-1
  function automatic logic [IW:0] rr_pick(input logic [REQUESTERS-1:0] v, input id_t p);
    logic [IW:0] r;
    int j;
    r = '0;
    for (int k = REQUESTERS - 1; k >= 0; k--) begin
      j = (int'(p) + k) % REQUESTERS;
      if (v[j]) r = {1'b1, IW'(j)};
    end
    return r;
  endfunction

  function automatic id_t rr_next(input id_t i);
    return (i == id_t'(REQUESTERS - 1)) ? '0 : i + 1'b1;
  endfunction

  id_t                   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_idx, wr_idx;
  logic                  m_r_avalid_q, m_r_avalid_d, m_w_valid_q, m_w_valid_d;
  logic [ADDR_WIDTH-1:0] m_r_addr_q, m_r_addr_d, m_w_addr_q, m_w_addr_d;
  logic [DATA_WIDTH-1:0] m_w_data_q, m_w_data_d;
  logic [IW:0]           rd_pick, wr_pick;
  logic                  rd_free, rd_gnt, wr_free, wr_gnt;
  id_t                   fifo_q [MAX_OUTSTANDING];
  id_t                   fifo_d [MAX_OUTSTANDING];
  logic [FW-1:0]         fh_q, fh_d, ft_q, ft_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  fifo_pop, fifo_room;

  assign fifo_pop    = m_r_dvalid && (cnt_q != '0);
  assign fifo_room   = (cnt_q != CW'(MAX_OUTSTANDING)) || fifo_pop;
  assign rq_r_dvalid = fifo_pop ? (REQUESTERS'(1) << fifo_q[fh_q]) : '0;
  assign rq_r_data   = fifo_pop ? m_r_data : '0;
  assign m_r_avalid  = m_r_avalid_q;
  assign m_r_addr    = m_r_addr_q;
  assign m_w_valid   = m_w_valid_q;
  assign m_w_addr    = m_w_addr_q;
  assign m_w_data    = m_w_data_q;

  // read channel: grant only when the stage is free and an ID slot is available
  always_comb begin
    rd_pick      = rr_pick(rq_r_avalid, rd_ptr_q);
    rd_idx       = rd_pick[IW-1:0];
    rd_free      = !m_r_avalid_q || m_r_aready;
    rd_gnt       = rd_pick[IW] && rd_free && fifo_room;
    rq_r_aready  = rd_gnt ? (REQUESTERS'(1) << rd_idx) : '0;
    m_r_avalid_d = rd_free ? rd_gnt : m_r_avalid_q;
    m_r_addr_d   = rd_gnt ? rq_r_addr[rd_idx*ADDR_WIDTH +: ADDR_WIDTH] : m_r_addr_q;
    rd_ptr_d     = rd_gnt ? rr_next(rd_idx) : rd_ptr_q;
  end

  // write channel: grant whenever the stage is free
  always_comb begin
    wr_pick     = rr_pick(rq_w_valid, wr_ptr_q);
    wr_idx      = wr_pick[IW-1:0];
    wr_free     = !m_w_valid_q || m_w_ready;
    wr_gnt      = wr_pick[IW] && wr_free;
    rq_w_ready  = wr_gnt ? (REQUESTERS'(1) << wr_idx) : '0;
    m_w_valid_d = wr_free ? wr_gnt : m_w_valid_q;
    m_w_addr_d  = wr_gnt ? rq_w_addr[wr_idx*ADDR_WIDTH +: ADDR_WIDTH] : m_w_addr_q;
    m_w_data_d  = wr_gnt ? rq_w_data[wr_idx*DATA_WIDTH +: DATA_WIDTH] : m_w_data_q;
    wr_ptr_d    = wr_gnt ? rr_next(wr_idx) : wr_ptr_q;
  end

  // ID FIFO: push the granted read requester, pop on each matched response
  always_comb begin
    fifo_d = fifo_q;
    if (rd_gnt) fifo_d[ft_q] = rd_idx;
    ft_d  = ft_q + FW'(rd_gnt);
    fh_d  = fh_q + FW'(fifo_pop);
    cnt_d = cnt_q + CW'(rd_gnt) - CW'(fifo_pop);
  end

`ifdef MEM_ARB_RESP_CHECK_EN
  logic err_q, err_d;
  assign err_d    = err_q || (m_r_dvalid && (cnt_q == '0));
  assign resp_err = err_q;

  // sticky flag for a response arriving with no outstanding read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end
`endif

  // state registers; reset discards stages and outstanding IDs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      m_r_avalid_q <= 1'b0;
      m_r_addr_q   <= '0;
      m_w_valid_q  <= 1'b0;
      m_w_addr_q   <= '0;
      m_w_data_q   <= '0;
      fifo_q       <= '{default: '0};
      fh_q         <= '0;
      ft_q         <= '0;
      cnt_q        <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      m_r_avalid_q <= m_r_avalid_d;
      m_r_addr_q   <= m_r_addr_d;
      m_w_valid_q  <= m_w_valid_d;
      m_w_addr_q   <= m_w_addr_d;
      m_w_data_q   <= m_w_data_d;
      fifo_q       <= fifo_d;
      fh_q         <= fh_d;
      ft_q         <= ft_d;
      cnt_q        <= cnt_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: directed and random checks of mem_arbiter_rr against a queue-based reference model
module tb_mem_arbiter_rr;
  localparam int R = 3, DW = 16, AW = 16, MO = 4;
  logic clk = 1'b0, reset_n;
  logic [R*AW-1:0] rq_r_addr, rq_w_addr;
  logic [R*DW-1:0] rq_w_data;
  logic [R-1:0] rq_r_avalid, rq_r_aready, rq_r_dvalid, rq_w_valid, rq_w_ready;
  logic [DW-1:0] rq_r_data, m_r_data, m_w_data;
  logic [AW-1:0] m_r_addr, m_w_addr;
  logic m_r_avalid, m_r_aready, m_r_dvalid, m_w_valid, m_w_ready;
`ifdef MEM_ARB_RESP_CHECK_EN
  logic resp_err;
`endif
  int checks = 0, failures = 0;
  int rptr, wptr;
  int idq[$];
  logic rs_v, ws_v;
  logic [AW-1:0] rs_a, ws_a;
  logic [DW-1:0] ws_d;
  logic [R-1:0] racc, wacc;
  logic [R-1:0] ooo_exp[3] = '{3'b100, 3'b001, 3'b010};
  int ooo_id[3] = '{2, 0, 1};

  mem_arbiter_rr #(.REQUESTERS(R), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)) dut (
`ifdef MEM_ARB_RESP_CHECK_EN
    .resp_err(resp_err),
`endif
    .clk(clk), .reset_n(reset_n),
    .rq_r_addr(rq_r_addr), .rq_r_avalid(rq_r_avalid), .rq_r_aready(rq_r_aready),
    .rq_r_dvalid(rq_r_dvalid), .rq_r_data(rq_r_data),
    .rq_w_addr(rq_w_addr), .rq_w_data(rq_w_data), .rq_w_valid(rq_w_valid), .rq_w_ready(rq_w_ready),
    .m_r_addr(m_r_addr), .m_r_avalid(m_r_avalid), .m_r_aready(m_r_aready),
    .m_r_dvalid(m_r_dvalid), .m_r_data(m_r_data),
    .m_w_addr(m_w_addr), .m_w_data(m_w_data), .m_w_valid(m_w_valid), .m_w_ready(m_w_ready));

  always #5 clk = ~clk;

  function automatic int pick(logic [R-1:0] v, int p);
    for (int k = 0; k < R; k++) if (v[(p + k) % R]) return (p + k) % R;
    return -1;
  endfunction

  task automatic chk(string n, logic [63:0] o, logic [63:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", n, o, e);
    end
  endtask

  task automatic model_reset();
    rptr = 0; wptr = 0; idq.delete();
    rs_v = 0; ws_v = 0; rs_a = '0; ws_a = '0; ws_d = '0;
    racc = '0; wacc = '0;
  endtask

  task automatic clear_inputs();
    rq_r_addr = '0; rq_w_addr = '0; rq_w_data = '0;
    rq_r_avalid = '0; rq_w_valid = '0;
    m_r_aready = 0; m_r_dvalid = 0; m_r_data = '0; m_w_ready = 0;
  endtask

  task automatic step();
    bit rfree, wfree, pop;
    int rg, wg;
    logic [R-1:0] ea, ew, ed;
    #4;
    pop   = m_r_dvalid && idq.size() > 0;
    rfree = !rs_v || m_r_aready;
    wfree = !ws_v || m_w_ready;
    rg = (rfree && (idq.size() < MO || pop)) ? pick(rq_r_avalid, rptr) : -1;
    wg = wfree ? pick(rq_w_valid, wptr) : -1;
    ea = (rg >= 0) ? R'(1) << rg : '0;
    ew = (wg >= 0) ? R'(1) << wg : '0;
    ed = pop ? R'(1) << idq[0] : '0;
    chk("rq_r_aready", rq_r_aready, ea);
    chk("rq_w_ready", rq_w_ready, ew);
    chk("rq_r_dvalid", rq_r_dvalid, ed);
    if (pop) chk("rq_r_data", rq_r_data, m_r_data);
    chk("m_r_avalid", m_r_avalid, rs_v);
    if (rs_v) chk("m_r_addr", m_r_addr, rs_a);
    chk("m_w_valid", m_w_valid, ws_v);
    if (ws_v) begin
      chk("m_w_addr", m_w_addr, ws_a);
      chk("m_w_data", m_w_data, ws_d);
    end
    @(posedge clk);
    racc = ea; wacc = ew;
    if (pop) void'(idq.pop_front());
    if (rfree) rs_v = rg >= 0;
    if (rg >= 0) begin
      rs_a = rq_r_addr[rg*AW +: AW];
      idq.push_back(rg);
      rptr = (rg + 1) % R;
    end
    if (wfree) ws_v = wg >= 0;
    if (wg >= 0) begin
      ws_a = rq_w_addr[wg*AW +: AW];
      ws_d = rq_w_data[wg*DW +: DW];
      wptr = (wg + 1) % R;
    end
    #1;
  endtask

  initial begin
    reset_n = 0;
    clear_inputs();
    model_reset();
    #12;
    chk("reset_outputs", {rq_r_aready, rq_r_dvalid, rq_w_ready, m_r_avalid, m_w_valid}, '0);
    chk("reset_mem_addr", {m_r_addr, m_w_addr, m_w_data, rq_r_data}, '0);
`ifdef MEM_ARB_RESP_CHECK_EN
    chk("reset_resp_err", resp_err, 0);
`endif
    @(posedge clk); #1;
    reset_n = 1;
    // single requester read
    m_r_aready = 1; m_w_ready = 1;
    rq_r_avalid = 3'b010; rq_r_addr[AW +: AW] = 16'h0010;
    step();
    chk("single_m_r_avalid", m_r_avalid, 1);
    chk("single_m_r_addr", m_r_addr, 16'h0010);
    rq_r_avalid = '0;
    step();
    step();
    m_r_dvalid = 1; m_r_data = 16'hBEEF;
    #1;
    chk("single_dvalid", rq_r_dvalid, 3'b010);
    chk("single_data", rq_r_data, 16'hBEEF);
    step();
    m_r_dvalid = 0;
    // write fairness
    rq_w_valid = 3'b111;
    for (int i = 0; i < R; i++) begin
      rq_w_addr[i*AW +: AW] = AW'(16'hA0 + i);
      rq_w_data[i*DW +: DW] = DW'(16'h50 + i);
    end
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("fair_grant", rq_w_ready, R'(1) << (c % 3));
      step();
      chk("fair_m_w_addr", m_w_addr, AW'(16'hA0 + c % 3));
    end
    rq_w_valid = '0;
    step();
    // ID FIFO full, then grant in the same cycle as a pop
    rq_r_avalid = 3'b001; rq_r_addr[0 +: AW] = 16'h0100;
    for (int c = 0; c < MO; c++) step();
    #1;
    chk("fifo_full_block", rq_r_aready, '0);
    step();
    m_r_dvalid = 1; m_r_data = 16'h1234;
    #1;
    chk("fifo_pop_grant", rq_r_aready, 3'b001);
    chk("fifo_pop_route", rq_r_dvalid, 3'b001);
    step();
    rq_r_avalid = '0;
    for (int c = 0; c < MO; c++) step();
    m_r_dvalid = 0;
    // responses routed by issue order
    for (int c = 0; c < 3; c++) begin
      rq_r_avalid = R'(1) << ooo_id[c];
      rq_r_addr[ooo_id[c]*AW +: AW] = AW'(16'h200 + c);
      step();
    end
    rq_r_avalid = '0;
    for (int c = 0; c < 3; c++) begin
      m_r_dvalid = 1; m_r_data = DW'(c + 1);
      #1;
      chk("order_dvalid", rq_r_dvalid, ooo_exp[c]);
      chk("order_data", rq_r_data, DW'(c + 1));
      step();
    end
    m_r_dvalid = 0;
    // empty-FIFO response is dropped
    m_r_dvalid = 1; m_r_data = 16'hDEAD;
    step();
    m_r_dvalid = 0;
    // randomized traffic with requester-side hold
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < R; i++) begin
        if (!(rq_r_avalid[i] && !racc[i])) begin
          rq_r_avalid[i] = $urandom_range(0, 2) != 0;
          rq_r_addr[i*AW +: AW] = AW'($urandom);
        end
        if (!(rq_w_valid[i] && !wacc[i])) begin
          rq_w_valid[i] = $urandom_range(0, 2) != 0;
          rq_w_addr[i*AW +: AW] = AW'($urandom);
          rq_w_data[i*DW +: DW] = DW'($urandom);
        end
      end
      m_r_aready = $urandom_range(0, 3) != 0;
      m_w_ready  = $urandom_range(0, 3) != 0;
      m_r_dvalid = $urandom_range(0, 3) == 0;
      m_r_data   = DW'($urandom);
      step();
    end
    // reset with reads outstanding
    clear_inputs();
    m_r_aready = 1;
    rq_r_avalid = 3'b101;
    step();
    step();
    clear_inputs();
    reset_n = 0;
    #1;
    chk("midreset_outputs", {rq_r_aready, rq_r_dvalid, rq_w_ready, m_r_avalid, m_w_valid}, '0);
    chk("midreset_addr", {m_r_addr, m_w_addr, m_w_data}, '0);
    @(posedge clk); #1;
    reset_n = 1;
    model_reset();
    m_r_dvalid = 1; m_r_data = 16'h7777;
    #1;
    chk("after_reset_drop", rq_r_dvalid, '0);
    step();
    m_r_dvalid = 0;
`ifdef MEM_ARB_RESP_CHECK_EN
    chk("resp_err_set", resp_err, 1);
    step();
    chk("resp_err_sticky", resp_err, 1);
`else
    step();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- N-requester to 1-memory-port arbiter for the split read/write memory interface (read: addr/avalid/aready then dvalid/data; write: addr/data/valid/ready).
- Generalises the fixed 3-requester, 16-bit setup to parametrised count, widths and outstanding-read depth.
- Independent round-robin arbiters for the read and write channels; registered command stage toward memory.
- In-order read responses are routed back to the issuing requester via an ID FIFO.

Parameters:
REQUESTERS, 3, number of requester ports (>=2)
DATA_WIDTH, 16, data bus width
ADDR_WIDTH, 16, address bus width
MAX_OUTSTANDING, 4, read ID FIFO depth (power of 2, >=2)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
rq_r_addr  in  REQUESTERS*ADDR_WIDTH  per-requester read address, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
rq_r_avalid  in  REQUESTERS  read address valid
rq_r_aready  out  REQUESTERS  read address accepted
rq_r_dvalid  out  REQUESTERS  read data valid, one-hot or zero
rq_r_data  out  DATA_WIDTH  read data, shared by all requesters, qualified by rq_r_dvalid
rq_w_addr  in  REQUESTERS*ADDR_WIDTH  write address
rq_w_data  in  REQUESTERS*DATA_WIDTH  write data
rq_w_valid  in  REQUESTERS  write valid
rq_w_ready  out  REQUESTERS  write accepted
m_r_addr  out  ADDR_WIDTH  memory read address
m_r_avalid  out  1  memory read address valid
m_r_aready  in  1  memory read address ready
m_r_dvalid  in  1  memory read data valid, in order, no backpressure
m_r_data  in  DATA_WIDTH  memory read data
m_w_addr  out  ADDR_WIDTH  memory write address
m_w_data  out  DATA_WIDTH  memory write data
m_w_valid  out  1  memory write valid
m_w_ready  in  1  memory write ready

Behaviour:
- Reset: asynchronous on reset_n low; async assert, sync deassert assumed from the reset source.
  - All outputs 0.
  - Both round-robin pointers select requester 0 as highest priority.
  - ID FIFO empty.
- Handshakes: a transfer occurs when valid && ready in the same rising edge; valid/addr/data are held stable while valid && !ready on both sides.
- Command stage:
  - One register stage per channel; stage "free" = !m_x_valid || m_x_ready.
  - Grant computed combinationally each cycle: highest-priority requester with valid set, searched from pointer upward with wrap at REQUESTERS-1 -> 0.
  - Read grant additionally requires the ID FIFO not full, counting the pop in the same cycle.
  - At most one aready/w_ready bit high per channel per cycle, only for the granted requester and only when the stage is free.
- On grant:
  - Stage loads addr/data; m_x_valid=1 next cycle (latency 1 cycle).
  - Pointer = granted index + 1 (mod REQUESTERS).
  - For reads, the granted index is pushed into the ID FIFO.
- No grant and stage accepted: m_x_valid=0 next cycle; pointer unchanged.
- Read response:
  - On m_r_dvalid, pop the FIFO head.
  - rq_r_dvalid[head]=1 and rq_r_data=m_r_data combinationally, 0 latency; all other rq_r_dvalid bits 0.
  - Push and pop in the same cycle are both honoured; count unchanged.
- Boundaries:
  - FIFO full: read grants are blocked; a grant is allowed in a cycle with a simultaneous pop.
  - m_r_dvalid with FIFO empty: response dropped, no rq_r_dvalid asserted.
  - Full-rate operation: with m_x_ready held 1, one transfer per cycle per channel.
  - Read and write channels are fully independent; no ordering between them is enforced.
  - Reset mid-operation: stages, FIFO and outstanding IDs are discarded; the memory is reset alongside.

Optional Feature:
- Macro MEM_ARB_RESP_CHECK_EN.
- Defined: extra output port resp_err (1 bit, reset 0). Sticky 1 after any m_r_dvalid with FIFO empty; cleared only by reset.
- Not defined: port and logic absent; an unexpected response is silently dropped.

Test Plan:
- Single requester: r1 reads addr 0x0010; memory ready, data 0xBEEF 2 cycles later -> m_r_avalid one cycle after handshake with addr 0x0010; rq_r_dvalid=3'b010, rq_r_data=0xBEEF.
- Fairness: all 3 requesters hold w_valid, m_w_ready=1 for 6 cycles -> grant order 0,1,2,0,1,2; m_w_addr sequence follows.
- Backpressure: m_r_aready=0 for 5 cycles with avalid from r0 and r2 -> m_r_addr held stable; no further rq_r_aready after the first grant; traffic resumes when ready returns.
- FIFO full (MAX_OUTSTANDING=4): issue 4 reads with no responses -> 5th read not accepted. A response arriving in the same cycle as the 5th request -> 5th accepted that cycle, data routed to the oldest requester.
- Out-of-order IDs: reads issued by r2, r0, r1; responses 0x1,0x2,0x3 -> rq_r_dvalid pulses 100, 001, 010 with matching data.
- Reset and error check (macro defined): pulse reset_n with 2 reads outstanding, then m_r_dvalid=1 -> no rq_r_dvalid, resp_err=1 and stays 1.
